// File: rtl/hex_display_scanner.sv
// Scanned 7-segment hex viewer for NUM_CH probe words, with a debounced channel-step button and a freeze input.
// Define HEX_DISP_LZB_EN to enable leading-zero blanking.
module hex_display_scanner #(
   parameter int  DATA_WIDTH   = 32,
   parameter int  NUM_CH       = 4,
   parameter int  NUM_DIGITS   = 8,
   parameter int  PRESCALE     = 50000,
   parameter int  DEBOUNCE_CYC = 500000,
   localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
   input  logic                         btn_next,
   input  logic                         freeze,
   output logic [6:0]                   seg_out,
   output logic [NUM_DIGITS-1:0]        digit_en,
   output logic [CH_W-1:0]              ch_idx
);

   localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int PRE_W = $clog2(PRESCALE);
   localparam int DB_W  = $clog2(DEBOUNCE_CYC);
   localparam int NIB_W = (DATA_WIDTH + 3) / 4;
   localparam int PAD_W = 4 * ((NIB_W > NUM_DIGITS) ? NIB_W : NUM_DIGITS);

   typedef enum logic {LVL_LOW, LVL_HIGH} lvl_t;

   lvl_t                  lvl_q, lvl_d;
   logic                  sync1, sync2;
   logic [DB_W-1:0]       db_q, db_d;
   logic                  rise_d, step_q, reload_q;
   logic [DATA_WIDTH-1:0] ch_sel, snap_q;
   logic [PAD_W-1:0]      snap_pad;
   logic [PRE_W-1:0]      pre_q;
   logic [DIG_W-1:0]      dig_q, dig_nxt;
   logic                  lit_q;
   logic [3:0]            nib;
   logic                  blank;
   logic [6:0]            seg_nxt;
`ifdef HEX_DISP_LZB_EN
   logic [NUM_DIGITS:0]   zero_from;
`endif

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: return 7'h40;
         4'h1: return 7'h79;
         4'h2: return 7'h24;
         4'h3: return 7'h30;
         4'h4: return 7'h19;
         4'h5: return 7'h12;
         4'h6: return 7'h02;
         4'h7: return 7'h78;
         4'h8: return 7'h00;
         4'h9: return 7'h10;
         4'hA: return 7'h08;
         4'hB: return 7'h03;
         4'hC: return 7'h46;
         4'hD: return 7'h21;
         4'hE: return 7'h06;
         default: return 7'h0E;
      endcase
   endfunction

   // Accepted button level: a differing level must persist DEBOUNCE_CYC cycles
   always_comb begin
      lvl_d  = lvl_q;
      db_d   = '0;
      rise_d = 1'b0;
      if (sync2 != (lvl_q == LVL_HIGH)) begin
         if (db_q == DB_W'(DEBOUNCE_CYC - 1)) begin
            lvl_d  = sync2 ? LVL_HIGH : LVL_LOW;
            rise_d = sync2;
         end else begin
            db_d = db_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         lvl_q    <= LVL_LOW;
         db_q     <= '0;
         step_q   <= 1'b0;
         reload_q <= 1'b0;
         ch_idx   <= '0;
      end else begin
         sync1    <= btn_next;
         sync2    <= sync1;
         lvl_q    <= lvl_d;
         db_q     <= db_d;
         step_q   <= rise_d;
         reload_q <= step_q;
         if (step_q) begin
            ch_idx <= (ch_idx == CH_W'(NUM_CH - 1)) ? '0 : ch_idx + 1'b1;
         end
      end
   end

   always_comb begin
      ch_sel = ch_data[ch_idx*DATA_WIDTH +: DATA_WIDTH];
   end

   // reload_q forces one load from the newly selected channel even while frozen
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         snap_q <= '0;
      end else if (!freeze || reload_q) begin
         snap_q <= ch_sel;
      end
   end

   always_comb begin
      snap_pad = PAD_W'(snap_q);
      if (!lit_q || dig_q == DIG_W'(NUM_DIGITS - 1)) begin
         dig_nxt = '0;
      end else begin
         dig_nxt = dig_q + 1'b1;
      end
      nib   = snap_pad[dig_nxt*4 +: 4];
      blank = (32'(dig_nxt) >= NIB_W);
`ifdef HEX_DISP_LZB_EN
      zero_from             = '0;
      zero_from[NUM_DIGITS] = 1'b1;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         zero_from[NUM_DIGITS-1-i] = zero_from[NUM_DIGITS-i]
                                     && (snap_pad[(NUM_DIGITS-1-i)*4 +: 4] == 4'h0);
      end
      blank = blank || ((dig_nxt != '0) && zero_from[dig_nxt]);
`endif
      seg_nxt = blank ? 7'h7F : hex7(nib);
   end

   // Outputs are decoded from the next digit index so segments and enable switch together
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pre_q    <= '0;
         dig_q    <= '0;
         lit_q    <= 1'b0;
         seg_out  <= 7'h7F;
         digit_en <= '1;
      end else if (pre_q == PRE_W'(PRESCALE - 1)) begin
         pre_q    <= '0;
         dig_q    <= dig_nxt;
         lit_q    <= 1'b1;
         seg_out  <= seg_nxt;
         digit_en <= ~(NUM_DIGITS'(1) << dig_nxt);
      end else begin
         pre_q <= pre_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner: expected displayed words are queued and checked per digit slot.
module tb_hex_display_scanner;

   logic         clk;
   logic         rstn;
   logic [127:0] ch_data;
   logic         btn_next;
   logic         freeze;
   logic [6:0]   seg_out;
   logic [7:0]   digit_en;
   logic [1:0]   ch_idx;

   int           checks;
   int           failures;
   int           cyc;
   logic [31:0]  sb[$];

   hex_display_scanner #(
      .DATA_WIDTH   (32),
      .NUM_CH       (4),
      .NUM_DIGITS   (8),
      .PRESCALE     (4),
      .DEBOUNCE_CYC (3)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .ch_data  (ch_data),
      .btn_next (btn_next),
      .freeze   (freeze),
      .seg_out  (seg_out),
      .digit_en (digit_en),
      .ch_idx   (ch_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edges since reset release; digit slots update at every 4th edge
   always @(posedge clk or negedge rstn) begin
      if (!rstn) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [6:0] exp_seg(input logic [31:0] v, input int d);
      logic [3:0] n;
      n = v[d*4 +: 4];
`ifdef HEX_DISP_LZB_EN
      if (d > 0 && (v >> (d*4)) == 32'd0) return 7'h7F;
`endif
      case (n)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_slot(input string tag);
      int          n;
      int          d;
      logic [31:0] v;
      logic [7:0]  en_exp;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((cyc == 0 || (cyc % 4) != 0) && n < 8);
      checks++;
      assert (cyc != 0 && (cyc % 4) == 0 && sb.size() != 0) else begin
         failures++;
         $error("FAIL %s_slot observed=cyc%0d/queued%0d expected=aligned/nonempty", tag, cyc, sb.size());
      end
      if (sb.size() != 0) begin
         v      = sb.pop_front();
         d      = ((cyc / 4) + 7) % 8;
         en_exp = ~(8'h01 << d);
         chk(tag, {17'd0, digit_en, seg_out}, {17'd0, en_exp, exp_seg(v, d)});
      end
   endtask

   task automatic press(input int hi, input int lo);
      btn_next = 1'b1;
      repeat (hi) @(negedge clk);
      btn_next = 1'b0;
      repeat (lo) @(negedge clk);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rstn     = 1'b0;
      btn_next = 1'b0;
      freeze   = 1'b0;
      ch_data  = '0;
      ch_data[31:0] = 32'h89AB_CDEF;

      // Reset and dark period
      repeat (3) @(negedge clk);
      chk("rst_seg", {25'd0, seg_out}, 32'h7F);
      chk("rst_en", {24'd0, digit_en}, 32'hFF);
      chk("rst_ch", {30'd0, ch_idx}, 32'd0);
      rstn = 1'b1;
      chk("dark0", {17'd0, digit_en, seg_out}, {17'd0, 8'hFF, 7'h7F});
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         chk("dark", {17'd0, digit_en, seg_out}, {17'd0, 8'hFF, 7'h7F});
      end

      // Full scan of ch0 plus wrap back to digit 0
      for (int i = 0; i < 9; i++) sb.push_back(32'h89AB_CDEF);
      for (int i = 0; i < 9; i++) check_slot("scan");

      // Short glitch is ignored
      press(2, 10);
      chk("glitch", {30'd0, ch_idx}, 32'd0);

      // Exact press latency: 6 edges from the rise
      btn_next = 1'b1;
      repeat (5) @(negedge clk);
      chk("lat5", {30'd0, ch_idx}, 32'd0);
      @(negedge clk);
      chk("lat6", {30'd0, ch_idx}, 32'd1);
      repeat (4) @(negedge clk);
      btn_next = 1'b0;
      repeat (8) @(negedge clk);
      chk("press1", {30'd0, ch_idx}, 32'd1);
      press(8, 8);
      chk("press2", {30'd0, ch_idx}, 32'd2);
      press(8, 8);
      chk("press3", {30'd0, ch_idx}, 32'd3);
      press(8, 8);
      chk("wrap", {30'd0, ch_idx}, 32'd0);

      // Freeze holds the snapshot while ch1 changes
      ch_data[63:32] = 32'h0000_0012;
      press(8, 8);
      chk("sel1", {30'd0, ch_idx}, 32'd1);
      freeze = 1'b1;
      @(negedge clk);
      ch_data[63:32] = 32'h0000_0034;
      for (int i = 0; i < 8; i++) sb.push_back(32'h0000_0012);
      for (int i = 0; i < 8; i++) check_slot("frozen");
      freeze = 1'b0;
      for (int i = 0; i < 8; i++) sb.push_back(32'h0000_0034);
      for (int i = 0; i < 8; i++) check_slot("unfrozen");

      // Step while frozen reloads once from the new channel, then holds
      freeze = 1'b1;
      ch_data[95:64] = 32'h0000_ABCD;
      btn_next = 1'b1;
      repeat (6) @(negedge clk);
      chk("sel2", {30'd0, ch_idx}, 32'd2);
      repeat (2) @(negedge clk);
      ch_data[95:64] = 32'h0000_1111;
      repeat (2) @(negedge clk);
      btn_next = 1'b0;
      repeat (8) @(negedge clk);
      for (int i = 0; i < 8; i++) sb.push_back(32'h0000_ABCD);
      for (int i = 0; i < 8; i++) check_slot("stepfrz");

      // Asynchronous reset mid-cycle
      @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      chk("arst_seg", {25'd0, seg_out}, 32'h7F);
      chk("arst_en", {24'd0, digit_en}, 32'hFF);
      chk("arst_ch", {30'd0, ch_idx}, 32'd0);
      freeze = 1'b0;
      ch_data[31:0] = 32'h0000_0105;
      @(negedge clk);
      rstn = 1'b1;

      // Leading zeros: shown in the default build, blanked with HEX_DISP_LZB_EN
      for (int i = 0; i < 8; i++) sb.push_back(32'h0000_0105);
      for (int i = 0; i < 8; i++) check_slot("lead105");
      ch_data[31:0] = 32'h0000_0000;
      for (int i = 0; i < 8; i++) sb.push_back(32'h0000_0000);
      for (int i = 0; i < 8; i++) check_slot("zero");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
